// File: rtl/polytris_pkg.sv
// Shared board constants, types and cell helpers for the polytris board logic.
package polytris_pkg;

  localparam int unsigned ROWS   = 30;
  localparam int unsigned COLS   = 10;
  localparam int unsigned ROW_W  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 5;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_RD,
    SCAN_CHK,
    SHIFT_RD,
    SHIFT_WR,
    TOP_CLR,
    FIN
  } lc_state_t;

  // A cell is occupied when either bit of its 2-bit code is set.
  function automatic logic cell_occupied(row_t r, int c);
    return |r[2*c +: 2];
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row test; bits above the playfield columns are ignored.
module row_full_detect
  import polytris_pkg::*;
(
  input  row_t row,
  output logic full
);

  // AND together the occupancy of every playfield cell
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < int'(COLS); c++) begin
      full = full & cell_occupied(row, c);
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// Scans the board RAM bottom-up after a piece lock, removing full rows by
// shifting everything above down one row and blanking row 0.
module line_clear_engine
  import polytris_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  LINES_CLEARED,
  output logic [ADDR_W-1:0] RAM_ROW_ADDR,
  output logic              RAM_RE,
  output logic              RAM_WE,
  output row_t              RAM_WDATA,
  input  row_t              RAM_RDATA
);

  lc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy_d, done_d, re_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  lines_d;
  logic              row_full;

  row_full_detect u_full (
    .row  (RAM_RDATA),
    .full (row_full)
  );

  // Shift data is only valid in the write cycle itself (read latency of one),
  // so it is forwarded straight from the RAM; otherwise zero (top-row clear).
  assign RAM_WDATA = (state_q == SHIFT_WR) ? RAM_RDATA : '0;

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    lines_d = LINES_CLEARED;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          row_d   = ADDR_W'(ROWS - 1);
          cnt_d   = '0;
          state_d = SCAN_RD;
        end
      end
      SCAN_RD: state_d = SCAN_CHK;
      SCAN_CHK: begin
        if (row_full) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (row_q == '0) begin
            state_d = TOP_CLR;
          end else begin
            src_d   = row_q - ADDR_W'(1);
            state_d = SHIFT_RD;
          end
        end else if (row_q == '0) begin
          state_d = FIN;
        end else begin
          row_d   = row_q - ADDR_W'(1);
          state_d = SCAN_RD;
        end
      end
      SHIFT_RD: state_d = SHIFT_WR;
      SHIFT_WR: begin
        if (src_q == '0) begin
          state_d = TOP_CLR;
        end else begin
          src_d   = src_q - ADDR_W'(1);
          state_d = SHIFT_RD;
        end
      end
      TOP_CLR: state_d = SCAN_RD;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    re_d   = (state_d == SCAN_RD) || (state_d == SHIFT_RD);
    we_d   = (state_d == SHIFT_WR) || (state_d == TOP_CLR);
    unique case (state_d)
      SCAN_RD:  addr_d = row_d;
      SHIFT_RD: addr_d = src_d;
      SHIFT_WR: addr_d = src_d + ADDR_W'(1);
      default:  addr_d = '0;
    endcase
    if (state_d == FIN) lines_d = cnt_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      row_q         <= '0;
      src_q         <= '0;
      cnt_q         <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      LINES_CLEARED <= '0;
      RAM_RE        <= 1'b0;
      RAM_WE        <= 1'b0;
      RAM_ROW_ADDR  <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      src_q         <= src_d;
      cnt_q         <= cnt_d;
      BUSY          <= busy_d;
      DONE          <= done_d;
      LINES_CLEARED <= lines_d;
      RAM_RE        <= re_d;
      RAM_WE        <= we_d;
      RAM_ROW_ADDR  <= addr_d;
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine with a one-cycle-latency board RAM model.
module tb_line_clear_engine;
  import polytris_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              START;
  logic              BUSY, DONE;
  logic [CNT_W-1:0]  LINES_CLEARED;
  logic [ADDR_W-1:0] RAM_ROW_ADDR;
  logic              RAM_RE, RAM_WE;
  row_t              RAM_WDATA;
  row_t              rdata;

  row_t mem [0:ROWS-1];
  row_t img [0:ROWS-1];
  logic load;

  int tests_run = 0;
  int tests_failed = 0;
  int we_cnt = 0;
  int viol_cnt = 0;
  int we_in_pass;

  line_clear_engine dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .START         (START),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .LINES_CLEARED (LINES_CLEARED),
    .RAM_ROW_ADDR  (RAM_ROW_ADDR),
    .RAM_RE        (RAM_RE),
    .RAM_WE        (RAM_WE),
    .RAM_WDATA     (RAM_WDATA),
    .RAM_RDATA     (rdata)
  );

  always #5 CLK = ~CLK;

  // Board RAM: synchronous read, write-enable port, bulk preload from img
  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < int'(ROWS); i++) mem[i] <= img[i];
    end else begin
      if (RAM_RE) rdata <= mem[RAM_ROW_ADDR];
      if (RAM_WE) mem[RAM_ROW_ADDR] <= RAM_WDATA;
    end
  end

  // Protocol monitor: never RE and WE together, never either outside BUSY
  always @(negedge CLK) begin
    if (RAM_WE) we_cnt++;
    if ((RAM_RE && RAM_WE) || ((RAM_RE || RAM_WE) && !BUSY)) viol_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < int'(ROWS); i++) img[i] = '0;
  endtask

  task automatic load_board();
    load = 1'b1;
    @(negedge CLK);
    load = 1'b0;
  endtask

  // Count rows other than skip that are not zero
  function automatic int nonzero_rows(input int skip_a, input int skip_b);
    int n = 0;
    for (int i = 0; i < int'(ROWS); i++)
      if (i != skip_a && i != skip_b && mem[i] != '0) n++;
    return n;
  endfunction

  // Pulse START and count cycles until DONE (cycle 1 = cycle after acceptance)
  task automatic run_pass(output int cyc);
    int we0;
    we0 = we_cnt;
    START = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      START = 1'b0;
      cyc++;
    end while (!DONE && cyc < 2000);
    if (!DONE) check("done_timeout", 32'(cyc), 32'd0);
    we_in_pass = we_cnt - we0;
  endtask

  int cyc;
  int dones;
  int guard;

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    load    = 1'b0;
    clear_img();
    repeat (3) @(negedge CLK);

    check("rst_busy",  32'(BUSY), 32'd0);
    check("rst_done",  32'(DONE), 32'd0);
    check("rst_lines", 32'(LINES_CLEARED), 32'd0);
    check("rst_re",    32'(RAM_RE), 32'd0);
    check("rst_we",    32'(RAM_WE), 32'd0);
    check("rst_addr",  32'(RAM_ROW_ADDR), 32'd0);
    check("rst_wdata", RAM_WDATA, 32'd0);
    RESET_N = 1'b1;
    load_board();
    @(negedge CLK);

    // Empty board: DONE at cycle 61, no writes
    run_pass(cyc);
    check("t1_cycles", 32'(cyc), 32'd61);
    check("t1_lines",  32'(LINES_CLEARED), 32'd0);
    check("t1_we",     32'(we_in_pass), 32'd0);
    @(negedge CLK);
    check("t1_busy_after", 32'(BUSY), 32'd0);
    check("t1_done_pulse", 32'(DONE), 32'd0);

    // Bottom row full with one cell above
    clear_img();
    img[29] = 32'h000FFFFF;
    img[28] = 32'h00000003;
    load_board();
    run_pass(cyc);
    check("t2_cycles", 32'(cyc), 32'd122);
    check("t2_lines",  32'(LINES_CLEARED), 32'd1);
    check("t2_row29",  mem[29], 32'h00000003);
    check("t2_rest",   32'(nonzero_rows(29, 29)), 32'd0);
    @(negedge CLK);

    // Four stacked full rows (odd bit per cell only)
    clear_img();
    for (int i = 26; i < 30; i++) img[i] = 32'h000AAAAA;
    img[25] = 32'h00000300;
    load_board();
    run_pass(cyc);
    check("t3_cycles", 32'(cyc), 32'd305);
    check("t3_lines",  32'(LINES_CLEARED), 32'd4);
    check("t3_row29",  mem[29], 32'h00000300);
    check("t3_rest",   32'(nonzero_rows(29, 29)), 32'd0);
    @(negedge CLK);

    // Nine-cell row survives, full row 0 is blanked
    clear_img();
    img[15] = 32'h0003FFFF;
    img[0]  = 32'h000FFFFF;
    load_board();
    run_pass(cyc);
    check("t4_cycles", 32'(cyc), 32'd64);
    check("t4_lines",  32'(LINES_CLEARED), 32'd1);
    check("t4_row15",  mem[15], 32'h0003FFFF);
    check("t4_row0",   mem[0], 32'd0);
    @(negedge CLK);

    // Upper bits ignored for full test and preserved on shift
    clear_img();
    img[29] = 32'hF00FFFFF;
    img[28] = 32'hA0000001;
    load_board();
    run_pass(cyc);
    check("t5_lines", 32'(LINES_CLEARED), 32'd1);
    check("t5_row29", mem[29], 32'hA0000001);
    check("t5_row28", mem[28], 32'd0);
    @(negedge CLK);

    // START while busy and START during DONE are both ignored
    clear_img();
    load_board();
    START = 1'b1;
    dones = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      START = (i == 10);
      if (DONE) begin
        dones++;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("done_start_busy", 32'(BUSY), 32'd0);
      end
    end
    check("busy_start_dones", 32'(dones), 32'd1);

    // Reset during a shift write aborts immediately
    clear_img();
    img[29] = 32'h000FFFFF;
    img[10] = 32'h00000001;
    load_board();
    START = 1'b1;
    guard = 0;
    do begin
      @(negedge CLK);
      START = 1'b0;
      guard++;
    end while (!(RAM_WE && RAM_ROW_ADDR != '0) && guard < 500);
    check("rst_mid_found_wr", 32'(RAM_WE), 32'd1);
    RESET_N = 1'b0;
    @(negedge CLK);
    check("rst_mid_busy",  32'(BUSY), 32'd0);
    check("rst_mid_we",    32'(RAM_WE), 32'd0);
    check("rst_mid_lines", 32'(LINES_CLEARED), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    check("protocol_viol", 32'(viol_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
